// File: rtl/servo_pkg.sv
// Shared types, default limits and the saturating position helper for the
// servo track controller.
package servo_pkg;

  typedef enum logic {MANUAL, PLAY} mode_t;

  localparam int DEF_MIN_DUTY = 4;
  localparam int DEF_MAX_DUTY = 60;
  localparam int DEF_CENTER   = 32;

  // Wide signed arithmetic so that both overflow and underflow clamp cleanly.
  function automatic int sat_add(input int pos, input int delta, input int lo, input int hi);
    int s;
    s = pos + delta;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One PWM channel: latches its duty at frame start and compares it against
// the shared frame counter, so duty changes never produce runt pulses.
module servo_pwm_ch #(
  parameter int DW = 6
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic [DW-1:0] cnt,
  input  logic [DW-1:0] duty,
  output logic          pulse
);

  logic [DW-1:0] duty_lat;
  logic [DW-1:0] duty_now;

  assign duty_now = frame_start ? duty : duty_lat;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      duty_lat <= '0;
      pulse    <= 1'b0;
    end else begin
      if (frame_start) duty_lat <= duty;
      pulse <= (cnt < duty_now);
    end
  end

endmodule

// File: rtl/servo_track_ctrl.sv
// N-channel servo position controller with snapshot table playback and PWM.
// Optional feature macro: SERVO_SLEW_LIMIT_EN (rate-limits the applied duty).
module servo_track_ctrl
  import servo_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DW        = 6,
  parameter int DEPTH     = 8,
  parameter int STEP      = 1,
  parameter int MIN_DUTY  = DEF_MIN_DUTY,
  parameter int MAX_DUTY  = DEF_MAX_DUTY,
  parameter int CENTER    = DEF_CENTER,
  parameter int PRESCALE  = 4,
  parameter int DWELL_CYC = 16,
`ifdef SERVO_SLEW_LIMIT_EN
  parameter int SLEW_CYC  = 2,
`endif
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [N_CH-1:0]    btn_inc,
  input  logic [N_CH-1:0]    btn_dec,
  input  logic               store_btn,
  input  logic               clear_sw,
  input  logic               play_sw,
  output logic [N_CH-1:0]    pulse,
  output logic [N_CH*DW-1:0] duty_flat,
  output logic [CW-1:0]      mem_count,
  output logic               full,
  output logic               playing
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DWW  = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int PREW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [N_CH-1:0]    inc_q, inc_p, dec_q, dec_p;
  logic               store_q, store_p, clear_q, play_q;
  logic [N_CH-1:0]    inc_edge, dec_edge;
  logic               store_edge, store_fire;

  mode_t              mode;
  logic [DW-1:0]      pos_q  [N_CH];
  logic [DW-1:0]      duty_q [N_CH];
  logic [N_CH*DW-1:0] pos_flat;
  logic [N_CH*DW-1:0] mem_q  [DEPTH];
  logic [PTRW-1:0]    rd_ptr, rd_next, wr_idx;
  logic [CW-1:0]      rd_inc;
  logic [DWW-1:0]     dwell_cnt;

  logic [PREW-1:0]    pre_cnt;
  logic [DW-1:0]      pwm_cnt;
  logic               pwm_tick, frame_start;

  assign inc_edge   = inc_q & ~inc_p;
  assign dec_edge   = dec_q & ~dec_p;
  assign store_edge = store_q & ~store_p;
  assign full       = (mem_count == CW'(DEPTH));
  assign store_fire = !reset && (mode == MANUAL) && store_edge && !clear_q && !full;
  assign wr_idx     = PTRW'(mem_count);
  assign rd_inc     = CW'(rd_ptr) + CW'(1);
  assign rd_next    = (rd_inc >= mem_count) ? '0 : PTRW'(rd_inc);

  always_comb begin
    pos_flat  = '0;
    duty_flat = '0;
    for (int c = 0; c < N_CH; c++) begin
      pos_flat[c*DW +: DW]  = pos_q[c];
      duty_flat[c*DW +: DW] = duty_q[c];
    end
  end

  // The table itself has no reset; mem_count alone defines which entries are valid.
  always_ff @(posedge sysclk) begin
    if (store_fire) mem_q[wr_idx] <= pos_flat;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      inc_q     <= '0;
      inc_p     <= '0;
      dec_q     <= '0;
      dec_p     <= '0;
      store_q   <= 1'b0;
      store_p   <= 1'b0;
      clear_q   <= 1'b0;
      play_q    <= 1'b0;
      mode      <= MANUAL;
      playing   <= 1'b0;
      mem_count <= '0;
      rd_ptr    <= '0;
      dwell_cnt <= '0;
      for (int c = 0; c < N_CH; c++) pos_q[c] <= DW'(CENTER);
    end else begin
      inc_q   <= btn_inc;
      inc_p   <= inc_q;
      dec_q   <= btn_dec;
      dec_p   <= dec_q;
      store_q <= store_btn;
      store_p <= store_q;
      clear_q <= clear_sw;
      play_q  <= play_sw;
      case (mode)
        MANUAL: begin
          for (int c = 0; c < N_CH; c++) begin
            if (inc_edge[c] && !dec_edge[c])
              pos_q[c] <= DW'(sat_add(int'(pos_q[c]), STEP, MIN_DUTY, MAX_DUTY));
            else if (dec_edge[c] && !inc_edge[c])
              pos_q[c] <= DW'(sat_add(int'(pos_q[c]), -STEP, MIN_DUTY, MAX_DUTY));
          end
          if (clear_q)         mem_count <= '0;
          else if (store_fire) mem_count <= mem_count + CW'(1);
          // Entering playback overrides any same-cycle button move.
          if (play_q && !clear_q && (mem_count != '0)) begin
            mode      <= PLAY;
            playing   <= 1'b1;
            rd_ptr    <= '0;
            dwell_cnt <= '0;
            for (int c = 0; c < N_CH; c++) pos_q[c] <= mem_q[0][c*DW +: DW];
          end
        end
        PLAY: begin
          if (!play_q || clear_q) begin
            mode    <= MANUAL;
            playing <= 1'b0;
          end else if (dwell_cnt == DWW'(DWELL_CYC - 1)) begin
            dwell_cnt <= '0;
            rd_ptr    <= rd_next;
            for (int c = 0; c < N_CH; c++) pos_q[c] <= mem_q[rd_next][c*DW +: DW];
          end else begin
            dwell_cnt <= dwell_cnt + DWW'(1);
          end
        end
        default: begin
          mode    <= MANUAL;
          playing <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERVO_SLEW_LIMIT_EN
  localparam int SLW = (SLEW_CYC > 1) ? $clog2(SLEW_CYC) : 1;
  logic [SLW-1:0] slew_cnt;
  logic           slew_step;

  assign slew_step = (slew_cnt == SLW'(SLEW_CYC - 1));

  always_ff @(posedge sysclk) begin
    if (reset) begin
      slew_cnt <= '0;
      for (int c = 0; c < N_CH; c++) duty_q[c] <= DW'(CENTER);
    end else begin
      slew_cnt <= slew_step ? '0 : slew_cnt + SLW'(1);
      if (slew_step) begin
        for (int c = 0; c < N_CH; c++) begin
          if (duty_q[c] < pos_q[c])      duty_q[c] <= duty_q[c] + DW'(1);
          else if (duty_q[c] > pos_q[c]) duty_q[c] <= duty_q[c] - DW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) duty_q[c] <= DW'(CENTER);
    end else begin
      for (int c = 0; c < N_CH; c++) duty_q[c] <= pos_q[c];
    end
  end
`endif

  // One prescaler and frame counter shared by every channel keeps frames aligned.
  assign pwm_tick    = (pre_cnt == PREW'(PRESCALE - 1));
  assign frame_start = (pwm_cnt == '0) && (pre_cnt == '0);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= pwm_tick ? '0 : pre_cnt + PREW'(1);
      if (pwm_tick) pwm_cnt <= pwm_cnt + DW'(1);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    servo_pwm_ch #(.DW(DW)) u_pwm (
      .sysclk      (sysclk),
      .reset       (reset),
      .frame_start (frame_start),
      .cnt         (pwm_cnt),
      .duty        (duty_q[c]),
      .pulse       (pulse[c])
    );
  end

endmodule
